wave_capture_param: RTL and testbench



---
 rtl/wave_capture_param.sv | 156 +++++++++++++++
 tb/tb_wave_capture_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture_param.sv
// Triggered waveform capture into a double-buffered RAM: arms on a trigger condition, stores one
// decimated frame into the half the display is not reading, then waits for the display to swap.
module wave_capture_param #(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_sample_ready,
  input  logic [SAMPLE_W-1:0]   new_sample_in,
  input  logic [1:0]            trig_mode,
  input  logic [SAMPLE_W-1:0]   threshold,
  input  logic [3:0]            decim,
  input  logic                  wave_display_idle,
  output logic [DEPTH_LOG2:0]   write_address,
  output logic                  write_enable,
  output logic [OUT_W-1:0]      write_sample,
  output logic                  read_index,
  output logic                  armed,
  output logic                  frame_done
);

  localparam logic [1:0] StArmed  = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;

  localparam logic [OUT_W-1:0] MsbMask = OUT_W'(1) << (OUT_W - 1);

  logic [1:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] offset_q, offset_d;
  logic [3:0]            dec_cnt_q, dec_cnt_d;
  logic [3:0]            decim_q, decim_d;
  logic                  prev_valid_q, prev_valid_d;
  logic [SAMPLE_W-1:0]   prev_q, prev_d;
  logic                  read_index_q, read_index_d;
  logic                  we_q, we_d;
  logic [DEPTH_LOG2:0]   waddr_q, waddr_d;
  logic [OUT_W-1:0]      wsample_q, wsample_d;
  logic                  frame_done_q, frame_done_d;

  logic                  trig;
  logic                  do_store;
  logic [DEPTH_LOG2-1:0] store_off;
  logic [OUT_W-1:0]      store_val;

  assign store_val = new_sample_in[SAMPLE_W-1 -: OUT_W] ^ MsbMask;

  always_comb begin
    unique case (trig_mode)
      2'b00:   trig = prev_valid_q && prev_q[SAMPLE_W-1] && !new_sample_in[SAMPLE_W-1];
      2'b01:   trig = prev_valid_q && !prev_q[SAMPLE_W-1] && new_sample_in[SAMPLE_W-1];
      2'b10:   trig = prev_valid_q && ($signed(prev_q) < $signed(threshold)) &&
                      ($signed(new_sample_in) >= $signed(threshold));
      default: trig = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    dec_cnt_d    = dec_cnt_q;
    decim_d      = decim_q;
    prev_valid_d = prev_valid_q;
    prev_d       = prev_q;
    read_index_d = read_index_q;
    waddr_d      = waddr_q;
    wsample_d    = wsample_q;
    we_d         = 1'b0;
    frame_done_d = 1'b0;
    do_store     = 1'b0;
    store_off    = offset_q;

    if (new_sample_ready) begin
      prev_d       = new_sample_in;
      prev_valid_d = 1'b1;
    end

    unique case (state_q)
      StArmed: begin
        if (new_sample_ready && trig) begin
          do_store  = 1'b1;
          store_off = '0;
          offset_d  = DEPTH_LOG2'(1);
          dec_cnt_d = '0;
          decim_d   = decim;
          state_d   = StActive;
        end
      end
      StActive: begin
        if (new_sample_ready) begin
          if (dec_cnt_q == decim_q) begin
            do_store  = 1'b1;
            dec_cnt_d = '0;
            offset_d  = offset_q + DEPTH_LOG2'(1);
            if (offset_q == '1) begin
              frame_done_d = 1'b1;
              state_d      = StWait;
            end
          end else begin
            dec_cnt_d = dec_cnt_q + 4'd1;
          end
        end
      end
      StWait: begin
        if (wave_display_idle) begin
          read_index_d = ~read_index_q;
          state_d      = StArmed;
        end
      end
      default: state_d = StArmed;
    endcase

    if (do_store) begin
      we_d      = 1'b1;
      waddr_d   = {~read_index_q, store_off};
      wsample_d = store_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StArmed;
      offset_q     <= '0;
      dec_cnt_q    <= '0;
      decim_q      <= '0;
      prev_valid_q <= 1'b0;
      prev_q       <= '0;
      read_index_q <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wsample_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      dec_cnt_q    <= dec_cnt_d;
      decim_q      <= decim_d;
      prev_valid_q <= prev_valid_d;
      prev_q       <= prev_d;
      read_index_q <= read_index_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wsample_q    <= wsample_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign write_address = waddr_q;
  assign write_enable  = we_q;
  assign write_sample  = wsample_q;
  assign read_index    = read_index_q;
  assign frame_done    = frame_done_q;
  assign armed         = (state_q == StArmed);

endmodule

// File: tb/tb_wave_capture_param.sv
// Self-checking bench for wave_capture_param: per-cycle comparison against a frame-level model,
// trigger/data vector tables and directed multi-cycle sequences.
module tb_wave_capture_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = '0;
  logic [1:0]  trig_mode = 2'b00;
  logic [15:0] threshold = '0;
  logic [3:0]  decim = '0;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  logic        armed;
  logic        frame_done;

  wave_capture_param dut (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .trig_mode        (trig_mode),
    .threshold        (threshold),
    .decim            (decim),
    .wave_display_idle(wave_display_idle),
    .write_address    (write_address),
    .write_enable     (write_enable),
    .write_sample     (write_sample),
    .read_index       (read_index),
    .armed            (armed),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 waiting for trigger, 1 capturing, 2 waiting for display.
  int m_ph, m_prev, m_pv, m_ri, m_dec, m_k, m_thr;
  int e_we, e_fd, e_addr, e_data;

  typedef struct {
    int mode;
    int thr;
    int p;
    int s;
    int trig;
  } trig_vec_t;

  typedef struct {
    int s;
    int data;
  } data_vec_t;

  trig_vec_t tv[8];
  data_vec_t dv[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_prev = 0; m_pv = 0; m_ri = 0; m_dec = 0; m_k = 0;
    e_we = 0; e_fd = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic compare_all();
    check("write_enable", int'(write_enable), e_we);
    check("frame_done", int'(frame_done), e_fd);
    check("write_address", int'(write_address), e_addr);
    check("write_sample", int'(write_sample), e_data);
    check("read_index", int'(read_index), m_ri);
    check("armed", int'(armed), (m_ph == 0) ? 1 : 0);
  endtask

  // One clock: drive at negedge, predict, compare at next negedge.
  task automatic step(input int rdy, input int s, input int idl);
    int ph0, st, idx, trig;
    new_sample_ready  = rdy[0];
    new_sample_in     = 16'(s);
    wave_display_idle = idl[0];
    ph0 = m_ph; st = 0; idx = 0; trig = 0;
    e_we = 0; e_fd = 0;
    if (ph0 == 2 && idl != 0) begin
      m_ri = 1 - m_ri;
      m_ph = 0;
    end
    if (rdy != 0) begin
      if (ph0 == 0) begin
        case (int'(trig_mode))
          0:       trig = (m_pv != 0 && m_prev < 0 && s >= 0) ? 1 : 0;
          1:       trig = (m_pv != 0 && m_prev >= 0 && s < 0) ? 1 : 0;
          2:       trig = (m_pv != 0 && m_prev < m_thr && s >= m_thr) ? 1 : 0;
          default: trig = 1;
        endcase
        if (trig != 0) begin
          m_ph = 1; m_dec = int'(decim); m_k = 0; st = 1; idx = 0;
        end
      end else if (ph0 == 1) begin
        m_k++;
        if (m_k % (m_dec + 1) == 0) begin
          st = 1;
          idx = m_k / (m_dec + 1);
          if (idx == 255) begin
            e_fd = 1;
            m_ph = 2;
          end
        end
      end
      m_prev = s;
      m_pv = 1;
    end
    if (st != 0) begin
      e_we = 1;
      e_addr = (m_ri != 0 ? 0 : 256) + idx;
      e_data = ((s >>> 8) + 128) & 255;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_thr(input int t);
    m_thr = t;
    threshold = 16'(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    new_sample_ready = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int cnt;
    int hit;

    tv[0] = '{mode: 0, thr: 0,    p: -5,   s: 3,    trig: 1};
    tv[1] = '{mode: 0, thr: 0,    p: 3,    s: 5,    trig: 0};
    tv[2] = '{mode: 0, thr: 0,    p: -1,   s: 0,    trig: 1};
    tv[3] = '{mode: 1, thr: 0,    p: 0,    s: -1,   trig: 1};
    tv[4] = '{mode: 1, thr: 0,    p: -1,   s: -2,   trig: 0};
    tv[5] = '{mode: 2, thr: 1000, p: 999,  s: 1000, trig: 1};
    tv[6] = '{mode: 2, thr: 1000, p: 1000, s: 2000, trig: 0};
    tv[7] = '{mode: 2, thr: -50,  p: -100, s: -50,  trig: 1};
    dv[0] = '{s: 32767,  data: 255};
    dv[1] = '{s: -32768, data: 0};
    dv[2] = '{s: -1,     data: 127};
    dv[3] = '{s: 0,      data: 128};

    model_reset();
    set_thr(0);
    do_reset();

    // Rising zero-cross frame into the upper half, then buffer swap.
    trig_mode = 2'b00; decim = 4'd0;
    step(1, -5, 0);
    step(1, 3, 0);
    check("trig_addr", int'(write_address), 9'h100);
    check("trig_data", int'(write_sample), 8'h80);
    for (int i = 0; i < 255; i++) step(1, rnd_sample(), 0);
    check("last_addr", int'(write_address), 9'h1FF);
    check("last_frame_done", int'(frame_done), 1);
    check("wait_not_armed", int'(armed), 0);
    step(1, 100, 0);
    check("wait_no_write", int'(write_enable), 0);
    step(0, 0, 1);
    check("swap_read_index", int'(read_index), 1);
    check("swap_armed", int'(armed), 1);
    trig_mode = 2'b11;
    step(1, 42, 0);
    check("frame2_addr", int'(write_address), 9'h000);

    // Abort mid-frame once offset 100 has been written.
    hit = 0;
    for (int i = 0; i < 300 && hit == 0; i++) begin
      step(1, rnd_sample(), 0);
      if (write_enable && write_address == 9'd100) hit = 1;
    end
    check("reach_offset_100", hit, 1);
    reset = 1'b0;
    new_sample_ready = 1'b1;
    #1;
    check("rst_we", int'(write_enable), 0);
    check("rst_read_index", int'(read_index), 0);
    @(negedge clk);
    check("rst_we_held", int'(write_enable), 0);
    model_reset();
    compare_all();
    reset = 1'b1;
    trig_mode = 2'b00;
    step(1, 3, 0);
    check("post_rst_no_trig", int'(armed), 1);

    // Trigger vector table.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      trig_mode = 2'(tv[i].mode);
      set_thr(tv[i].thr);
      step(1, tv[i].p, 0);
      step(1, tv[i].s, 0);
      check($sformatf("tbl_trig%0d", i), int'(!armed), tv[i].trig);
      check($sformatf("tbl_we%0d", i), int'(write_enable), tv[i].trig);
    end

    // Stored-data vector table, free-run with every sample stored.
    do_reset();
    trig_mode = 2'b11; decim = 4'd0;
    for (int i = 0; i < 4; i++) begin
      step(1, dv[i].s, 0);
      check($sformatf("data%0d", i), int'(write_sample), dv[i].data);
    end

    // Decimation by 3: frame completes after 766 accepted samples.
    do_reset();
    trig_mode = 2'b11; decim = 4'd2;
    cnt = 0;
    hit = 0;
    for (int i = 0; i < 2000 && hit == 0; i++) begin
      step(1, rnd_sample(), 0);
      cnt++;
      if (frame_done) hit = 1;
    end
    check("decim_frame_done", hit, 1);
    check("decim_accepted", cnt, 766);

    // Randomised traffic with live mode/threshold/decim changes.
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) == 0) trig_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) decim = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) set_thr(int'($urandom_range(0, 2000)) - 1000);
      step(($urandom_range(0, 2) != 0) ? 1 : 0,
           ($urandom_range(0, 1) != 0) ? rnd_sample() : int'($urandom_range(0, 2000)) - 1000,
           ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
